// File: rtl/decoder_nx2n_scan.sv
// decoder_nx2n_scan: registered N-to-2^N enable decoder with a scan mode.
// In direct mode the select A is decoded to a one-hot line. In scan mode the
// active line steps up or down once every DIV cycles, starting from A.
// WRAP pulses for one cycle when a step crosses the top/bottom boundary.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module decoder_nx2n_scan #(
    parameter int N       = 2,
    parameter int DIV     = 4,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                E,
    input  logic                MODE,
    input  logic                DIR,
    input  logic [N-1:0]        A,
    output logic [(1<<N)-1:0]   D,
    output logic [N-1:0]        IDX,
    output logic                WRAP
);

    // Number of decoded lines and prescaler counter width (at least one bit).
    localparam int W  = 1 << N;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    // Terminal prescaler value: a scan step happens when the count reaches it.
    localparam logic [CW-1:0] LAST_COUNT = CW'(DIV - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [N-1:0]  IDX_ONE    = N'(1);
    localparam logic [N-1:0]  IDX_MAX    = {N{1'b1}};
    localparam logic [N-1:0]  IDX_ZERO   = '0;

    // Inactive level for every line. XOR-ing the raw one-hot with this
    // mask applies the output polarity in one place.
    localparam logic [W-1:0] BLANK   = {W{ACT_LOW}};
    localparam logic [W-1:0] ONE_BIT = W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_nextCount;
    logic [N-1:0]    r_idx;
    logic [N-1:0]    w_nextIdx;
    logic [N-1:0]    w_stepIdx;
    logic            w_stepWrap;
    logic            r_wrap;
    logic            w_nextWrap;
    logic [W-1:0]    r_d;
    logic [W-1:0]    w_nextD;
    logic [W-1:0]    w_oneHot;

    // The neighbour index in the selected direction wraps naturally at N bits.
    // A step wraps when it leaves the top (up) or the bottom (down) line.
    assign w_stepIdx  = DIR ? (r_idx - IDX_ONE) : (r_idx + IDX_ONE);
    assign w_stepWrap = DIR ? (r_idx == IDX_ZERO) : (r_idx == IDX_MAX);

    // State register; reset forces IDLE regardless of the other inputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state depends only on enable and mode, re-evaluated every cycle.
    always_comb begin
        w_nextState = ST_IDLE;
        if (E) begin
            w_nextState = MODE ? ST_SCAN : ST_DIRECT;
        end
    end

    // Next index, prescaler count and wrap flag. Arriving in SCAN from any
    // other state reloads the index from A with a fresh, full period; every
    // non-scan state holds the count at zero so leaving SCAN clears it.
    always_comb begin
        w_nextIdx   = r_idx;
        w_nextCount = '0;
        w_nextWrap  = 1'b0;
        case (w_nextState)
            ST_DIRECT: begin
                w_nextIdx = A;
            end
            ST_SCAN: begin
                if (r_state != ST_SCAN) begin
                    w_nextIdx = A;
                end else if (r_count == LAST_COUNT) begin
                    w_nextIdx  = w_stepIdx;
                    w_nextWrap = w_stepWrap;
                end else begin
                    w_nextCount = r_count + COUNT_ONE;
                end
            end
            default: begin
                w_nextIdx = r_idx;
            end
        endcase
    end

    // Line outputs follow the index being loaded this cycle, blanked in IDLE.
    always_comb begin
        w_oneHot = ONE_BIT << w_nextIdx;
        w_nextD  = BLANK;
        if (w_nextState != ST_IDLE) begin
            w_nextD = w_oneHot ^ BLANK;
        end
    end

    // Datapath registers; these directly drive the module outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_idx   <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_d     <= BLANK;
        end else begin
            r_idx   <= w_nextIdx;
            r_count <= w_nextCount;
            r_wrap  <= w_nextWrap;
            r_d     <= w_nextD;
        end
    end

    assign D    = r_d;
    assign IDX  = r_idx;
    assign WRAP = r_wrap;

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Testbench for decoder_nx2n_scan. Three instances cover the default
// configuration (table-driven), DIV=1 scanning down, and an active-low
// 3-bit configuration (hand-written sequences).
module tb_decoder_nx2n_scan;

    logic clk = 1'b0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Instance 0: N=2, DIV=4, ACT_LOW=0
    logic       nrst0, e0, mode0, dir0;
    logic [1:0] a0;
    logic [3:0] d0;
    logic [1:0] idx0;
    logic       wrap0;

    // Instance 1: N=2, DIV=1, ACT_LOW=0
    logic       nrst1, e1, mode1, dir1;
    logic [1:0] a1;
    logic [3:0] d1;
    logic [1:0] idx1;
    logic       wrap1;

    // Instance 2: N=3, DIV=2, ACT_LOW=1
    logic       nrst2, e2, mode2, dir2;
    logic [2:0] a2;
    logic [7:0] d2;
    logic [2:0] idx2;
    logic       wrap2;

    decoder_nx2n_scan #(.N(2), .DIV(4), .ACT_LOW(1'b0)) dut0 (
        .clk(clk), .nrst(nrst0), .E(e0), .MODE(mode0), .DIR(dir0), .A(a0),
        .D(d0), .IDX(idx0), .WRAP(wrap0)
    );

    decoder_nx2n_scan #(.N(2), .DIV(1), .ACT_LOW(1'b0)) dut1 (
        .clk(clk), .nrst(nrst1), .E(e1), .MODE(mode1), .DIR(dir1), .A(a1),
        .D(d1), .IDX(idx1), .WRAP(wrap1)
    );

    decoder_nx2n_scan #(.N(3), .DIV(2), .ACT_LOW(1'b1)) dut2 (
        .clk(clk), .nrst(nrst2), .E(e2), .MODE(mode2), .DIR(dir2), .A(a2),
        .D(d2), .IDX(idx2), .WRAP(wrap2)
    );

    typedef struct {
        logic       nrst;
        logic       e;
        logic       mode;
        logic       dir;
        logic [1:0] a;
        logic [3:0] expD;
        logic [1:0] expIdx;
        logic       expWrap;
    } vec_t;

    vec_t tbl[$];

    int nChecks = 0;
    int nFails  = 0;

    task automatic addVec(input logic nrst, input logic e, input logic mode,
                          input logic dir, input logic [1:0] a,
                          input logic [3:0] expD, input logic [1:0] expIdx,
                          input logic expWrap);
        vec_t v;
        v.nrst = nrst; v.e = e; v.mode = mode; v.dir = dir; v.a = a;
        v.expD = expD; v.expIdx = expIdx; v.expWrap = expWrap;
        tbl.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int step,
                               input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        nrst0 = v.nrst;
        e0    = v.e;
        mode0 = v.mode;
        dir0  = v.dir;
        a0    = v.a;
    endtask

    logic [3:0] expD1[5]   = '{4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
    logic [1:0] expIdx1[5] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
    logic       expWrap1[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        nrst0 = 1'b0; e0 = 1'b1; mode0 = 1'b0; dir0 = 1'b0; a0 = 2'd0;
        nrst1 = 1'b0; e1 = 1'b1; mode1 = 1'b0; dir1 = 1'b0; a1 = 2'd0;
        nrst2 = 1'b0; e2 = 1'b1; mode2 = 1'b0; dir2 = 1'b0; a2 = 3'd0;

        //     nrst  e     mode  dir   a     D        IDX   WRAP
        // reset, then direct A=2
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 2'd0, 1'b0);
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 2'd0, 1'b0);
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0);
        // direct sweep, then blank with IDX held
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0);
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0);
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 2'd3, 1'b0);
        addVec(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 2'd3, 1'b0);
        // scan up from A=2, A ignored afterwards
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0100, 2'd2, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
        // count 1, count 2, then reset mid-scan
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0);
        addVec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd0, 1'b0);
        // release into scan from A=3: full period, then wrap to 0
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0001, 2'd0, 1'b1);
        // MODE 1->0->1 restarts scan from A=1 with a full period
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0001, 2'd0, 1'b0);
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0100, 2'd2, 1'b0);
        // DIR flips mid-period: count keeps running, next step goes down
        addVec(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0100, 2'd2, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0100, 2'd2, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0100, 2'd2, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0);

        // Table-driven run on instance 0
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput("dut0.D",    i, 8'(d0),    8'(tbl[i].expD));
            checkOutput("dut0.IDX",  i, 8'(idx0),  8'(tbl[i].expIdx));
            checkOutput("dut0.WRAP", i, 8'(wrap0), 8'(tbl[i].expWrap));
        end

        // Instance 1: DIV=1 scan down from A=1
        @(negedge clk);
        checkOutput("dut1.reset.D", 0, 8'(d1), 8'h00);
        nrst1 = 1'b1; e1 = 1'b1; mode1 = 1'b1; dir1 = 1'b1; a1 = 2'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a1 = 2'd2;
            checkOutput("dut1.D",    k, 8'(d1),    8'(expD1[k]));
            checkOutput("dut1.IDX",  k, 8'(idx1),  8'(expIdx1[k]));
            checkOutput("dut1.WRAP", k, 8'(wrap1), 8'(expWrap1[k]));
        end

        // Instance 2: active-low, N=3, DIV=2
        nrst2 = 1'b0; e2 = 1'b1; mode2 = 1'b0; a2 = 3'd5;
        @(negedge clk);
        checkOutput("dut2.reset.D",   0, d2, 8'hFF);
        checkOutput("dut2.reset.IDX", 0, 8'(idx2), 8'h00);
        nrst2 = 1'b1;
        @(negedge clk);
        checkOutput("dut2.direct.D",   1, d2, 8'hDF);
        checkOutput("dut2.direct.IDX", 1, 8'(idx2), 8'h05);
        mode2 = 1'b1; dir2 = 1'b0; a2 = 3'd7;
        @(negedge clk);
        checkOutput("dut2.scan.D",    2, d2, 8'h7F);
        checkOutput("dut2.scan.WRAP", 2, 8'(wrap2), 8'h00);
        a2 = 3'd0;
        @(negedge clk);
        checkOutput("dut2.scan.D",    3, d2, 8'h7F);
        @(negedge clk);
        checkOutput("dut2.scan.D",    4, d2, 8'hFE);
        checkOutput("dut2.scan.IDX",  4, 8'(idx2), 8'h00);
        checkOutput("dut2.scan.WRAP", 4, 8'(wrap2), 8'h01);
        @(negedge clk);
        checkOutput("dut2.scan.D",    5, d2, 8'hFE);
        checkOutput("dut2.scan.WRAP", 5, 8'(wrap2), 8'h00);
        e2 = 1'b0;
        @(negedge clk);
        checkOutput("dut2.idle.D",   6, d2, 8'hFF);
        checkOutput("dut2.idle.IDX", 6, 8'(idx2), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
